// File: rtl/ahb_arb_pkg.sv
// Shared definitions for the AHB-lite bus arbiter and the slave wrappers.
// Contents: arbiter state encoding, HResp codes, one-hot to index helper.
// Optional feature macro used by the arbiter: AHB_ARB_ROUND_ROBIN_EN.
package ahb_arb_pkg;

  localparam int unsigned MAX_MASTERS = 8;
  localparam int unsigned MAX_IDX_W   = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    OWNED = 1'b1
  } arb_state_t;

  // HResp encodings
  localparam logic [1:0] OKAY  = 2'b00;
  localparam logic [1:0] ERROR = 2'b01;
  localparam logic [1:0] RETRY = 2'b10;
  localparam logic [1:0] SPLIT = 2'b11;

  // OR-reduction encoder; exact for a one-hot input.
  function automatic logic [MAX_IDX_W-1:0] onehot_to_idx(input logic [MAX_MASTERS-1:0] oh);
    logic [MAX_IDX_W-1:0] idx;
    idx = '0;
    for (int unsigned i = 0; i < MAX_MASTERS; i++) begin
      if (oh[i]) idx = idx | MAX_IDX_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/ahb_arb_pick.sv
// Combinational winner picker for the bus arbiter.
// Ports: req (requests), excl (masters to ignore), start (round-robin origin),
//        valid (any eligible request), winner (index of the chosen master).
// AHB_ARB_ROUND_ROBIN_EN defined: first eligible at or after start (wrapping).
// Undefined: fixed priority, lowest index wins; start is ignored.
module ahb_arb_pick #(
  parameter int unsigned N = 2,
  parameter int unsigned W = 1
) (
  input  logic [N-1:0] req,
  input  logic [N-1:0] excl,
  input  logic [W-1:0] start,
  output logic         valid,
  output logic [W-1:0] winner
);

  logic [N-1:0] cand;

  assign cand  = req & ~excl;
  assign valid = |cand;

`ifdef AHB_ARB_ROUND_ROBIN_EN
  // Scan N positions beginning at start, first hit wins.
  always_comb begin
    logic        found;
    int unsigned idx;
    winner = '0;
    found  = 1'b0;
    idx    = 0;
    for (int unsigned i = 0; i < N; i++) begin
      idx = (32'(start) + i) % N;
      if (!found && cand[idx]) begin
        winner = W'(idx);
        found  = 1'b1;
      end
    end
  end
`else
  logic unused_start;
  assign unused_start = ^start;

  // Downward scan so the lowest eligible index is assigned last.
  always_comb begin
    winner = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (cand[i]) winner = W'(i);
    end
  end
`endif

endmodule

// File: rtl/ahb_bus_arbiter.sv
// AHB-lite system bus arbiter with hold-limited preemption and lock support.
// Ports: clk, rst (async active-high), HBusReq/HLock (per master), HReady,
//        HGrant (one-hot), HMaster (address-phase owner), HMasterData
//        (data-phase owner), HMasterLock, Parked (idle on DEFAULT_MASTER).
// Optional feature macro: AHB_ARB_ROUND_ROBIN_EN (round-robin winner choice).
module ahb_bus_arbiter
  import ahb_arb_pkg::*;
#(
  parameter int unsigned NUM_MASTERS    = 2,
  parameter int unsigned DEFAULT_MASTER = 0,
  parameter int unsigned MAX_HOLD       = 16,
  parameter int unsigned MW             = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_MASTERS-1:0] HBusReq,
  input  logic [NUM_MASTERS-1:0] HLock,
  input  logic                   HReady,
  output logic [NUM_MASTERS-1:0] HGrant,
  output logic [MW-1:0]          HMaster,
  output logic [MW-1:0]          HMasterData,
  output logic                   HMasterLock,
  output logic                   Parked
);

  localparam int unsigned HW = (MAX_HOLD < 2) ? 1 : $clog2(MAX_HOLD + 1);
  localparam logic [HW-1:0] HOLD_SAT = '1;
  localparam logic [NUM_MASTERS-1:0] DEF_GRANT = NUM_MASTERS'(1) << DEFAULT_MASTER;

  arb_state_t             state, state_nxt;
  logic [NUM_MASTERS-1:0] grant_nxt;
  logic [HW-1:0]          hold_cnt, hold_nxt;
  logic [MW-1:0]          owner;
  logic                   own_req, own_lock, hold_ok, stay;
  logic [MW-1:0]          start;
  logic                   any_valid, oth_valid;
  logic [MW-1:0]          any_idx, oth_idx;

  assign owner    = MW'(onehot_to_idx(MAX_MASTERS'(HGrant)));
  assign own_req  = HBusReq[owner];
  assign own_lock = HLock[owner];
  // hold_cnt < MAX_HOLD-1, written without underflow for MAX_HOLD=0
  assign hold_ok  = (MAX_HOLD == 0) || ((32'(hold_cnt) + 32'd1) < MAX_HOLD);
  // Stay when still requesting and any reason not to yield holds
  assign stay     = own_req && (own_lock || !oth_valid || hold_ok);

`ifdef AHB_ARB_ROUND_ROBIN_EN
  logic [MW-1:0] last_owner;
  assign start = MW'((32'(last_owner) + 32'd1) % NUM_MASTERS);

  // Remember the owner of every grant into OWNED
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_owner <= MW'(DEFAULT_MASTER);
    end else if (HReady && (state_nxt == OWNED)) begin
      last_owner <= MW'(onehot_to_idx(MAX_MASTERS'(grant_nxt)));
    end
  end
`else
  assign start = '0;
`endif

  // Winner among all requesters (used from IDLE)
  ahb_arb_pick #(.N(NUM_MASTERS), .W(MW)) u_pick_any (
    .req    (HBusReq),
    .excl   ('0),
    .start  (start),
    .valid  (any_valid),
    .winner (any_idx)
  );

  // Winner among requesters other than the current owner (handover)
  ahb_arb_pick #(.N(NUM_MASTERS), .W(MW)) u_pick_oth (
    .req    (HBusReq),
    .excl   (HGrant),
    .start  (start),
    .valid  (oth_valid),
    .winner (oth_idx)
  );

  // State and pipeline registers; everything holds while HReady=0
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      HGrant      <= DEF_GRANT;
      hold_cnt    <= '0;
      HMaster     <= MW'(DEFAULT_MASTER);
      HMasterData <= MW'(DEFAULT_MASTER);
      HMasterLock <= 1'b0;
      Parked      <= 1'b1;
    end else if (HReady) begin
      state       <= state_nxt;
      HGrant      <= grant_nxt;
      hold_cnt    <= hold_nxt;
      HMaster     <= owner;
      HMasterData <= HMaster;
      HMasterLock <= own_lock & own_req;
      Parked      <= (state_nxt == IDLE);
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_valid) state_nxt = OWNED;
      OWNED:   if (!own_req && !oth_valid) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Grant and hold-counter next values
  always_comb begin
    grant_nxt = HGrant;
    hold_nxt  = hold_cnt;
    case (state)
      IDLE: begin
        hold_nxt  = '0;
        grant_nxt = any_valid ? (NUM_MASTERS'(1) << any_idx) : DEF_GRANT;
      end
      OWNED: begin
        if (stay) begin
          hold_nxt = (hold_cnt == HOLD_SAT) ? hold_cnt : hold_cnt + HW'(1);
        end else if (oth_valid) begin
          hold_nxt  = '0;
          grant_nxt = NUM_MASTERS'(1) << oth_idx;
        end else begin
          hold_nxt  = '0;
          grant_nxt = DEF_GRANT;
        end
      end
      default: begin
        hold_nxt  = '0;
        grant_nxt = DEF_GRANT;
      end
    endcase
  end

  a_grant_onehot: assert property (@(posedge clk) disable iff (rst) $onehot(HGrant));

endmodule
